image_filter_engine: RTL and testbench
======================================

// Module: image_filter_engine
// PURPOSE
// Sweeps a raw 8-bit greyscale image in the image memory and writes one filtered pixel per source pixel.
// Reads use the memory's async read port (rA/RD); writes use its synchronous write port (wA/WD/WE).
// Operation per run: copy, invert, threshold, or 3-tap horizontal blur with edge replication.
// Sits between the raw-image load and the processed-image dump; one run per start pulse.
// PARAMETERS
// IMG_W    390     pixels per row (>=2)
// IMG_H    390     rows (>=1); IMG_W*IMG_H = 152100 default
// SRC_BASE 0       byte address of pixel (0,0) of the source image
// DST_BASE 0       byte address of pixel (0,0) of the destination image; may equal SRC_BASE (in-place)
// PORTS
// CLK    in  1   clock, all state on posedge
// RST_N  in  1   asynchronous active-low reset
// start  in  1   run request, sampled in IDLE only
// mode   in  2   00 copy, 01 invert, 10 threshold, 11 blur; latched at accepted start
// thr    in  8   threshold level; latched at accepted start
// rA     out 32  source read address to memory
// RD     in  8   read data from memory, valid same cycle as rA (async read)
// wA     out 32  destination write address (registered)
// WD     out 8   destination write data (registered)
// WE     out 1   write enable (registered)
// busy   out 1   high from first READ cycle through last WE cycle
// done   out 1   one-cycle pulse, cycle after the final WE
// BEHAVIOUR
// - Clock CLK, reset RST_N; reset asynchronous active-low. Reset: state IDLE, WE=0, wA=0, WD=0, rA=SRC_BASE, busy=0, done=0, counters 0.
// - Reset mid-run aborts immediately; WE drops with reset assertion; no resume.
// - States: IDLE -> READ (start=1) ; READ col==IMG_W-1 -> FLUSH ; FLUSH -> READ (more rows) or DRAIN (last row) ; DRAIN -> DONE -> IDLE.
// - start ignored outside IDLE. done high only in DONE.
// - Counters: col 0..IMG_W-1, row 0..IMG_H-1; row base kept by += IMG_W, no multiplier. rA = SRC_BASE+rowbase+col.
// - Window regs L, C (8b). READ, col==0: L<=RD, C<=RD, no write issued.
// - READ, col>0: issue write for column col-1 with (left,ctr,right)=(L,C,RD); then L<=C, C<=RD.
// - FLUSH: issue write for column IMG_W-1 with (L,C,C) (right-edge replication); rA held, RD unused.
// - Issued write appears on WE/wA/WD the following cycle: wA=DST_BASE+rowbase+column.
// - DRAIN: final write visible on WE; nothing new issued. In all other cycles without an issue, WE=0.
// - Per row IMG_W+1 cycles; busy high for IMG_H*(IMG_W+1)+1 cycles; exactly IMG_W*IMG_H writes, ascending addresses.
// - Pixel function f(left,ctr,right): copy=ctr; invert=255-ctr; threshold=(ctr>=thr)?255:0;
//   blur=(left+2*ctr+right)>>2 with a 10-bit sum, truncating (floor).
// - In-place (DST_BASE==SRC_BASE) is safe: column c-1 is written only after column c is read, and neighbours come from L/C.
// - thr/mode changes during a run have no effect.
// TESTING
// - W=4,H=2,blur, row0=[10,20,30,40] -> WD for addrs 0..3 = 12,20,30,37.
// - invert, pixels [0,200,255,1] -> [255,55,0,254]; copy -> identical image at DST_BASE=16.
// - threshold thr=128, pixels [127,128,0,255] -> [0,255,0,255].
// - W=4,H=2: start pulse -> busy high exactly 11 cycles, 8 WE cycles, done one cycle after last WE.
// - Assert RST_N low mid-row 1 -> WE/busy 0 at once, state IDLE; new start reruns from address 0.
// - In-place blur (SRC=DST=0) matches out-of-place golden model; start pulsed while busy -> ignored.

Source files
------------

// File: rtl/image_filter_engine.sv
// Streams an 8-bit greyscale image through a 3-tap horizontal window and writes one
// filtered pixel (copy/invert/threshold/blur) per source pixel back to memory.
module image_filter_engine #(
    parameter int unsigned IMG_W    = 390,
    parameter int unsigned IMG_H    = 390,
    parameter logic [31:0] SRC_BASE = 32'd0,
    parameter logic [31:0] DST_BASE = 32'd0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [7:0]  thr,
    output logic [31:0] rA,
    input  logic [7:0]  RD,
    output logic [31:0] wA,
    output logic [7:0]  WD,
    output logic        WE,
    output logic        busy,
    output logic        done
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [31:0]        rowbase_q, rowbase_d;
    logic [7:0]         l_q, l_d, c_q, c_d;
    logic [1:0]         mode_q, mode_d;
    logic [7:0]         thr_q, thr_d;
    logic [31:0]        ra_q, ra_d;
    logic [31:0]        wa_q, wa_d;
    logic [7:0]         wd_q, wd_d;
    logic               we_q, we_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Per-pixel operation on the (left, centre, right) window.
    function automatic logic [7:0] pix_f(input logic [1:0] m, input logic [7:0] t,
                                         input logic [7:0] lf, input logic [7:0] ct,
                                         input logic [7:0] rt);
        logic [9:0] sum;
        sum = {2'b00, lf} + {1'b0, ct, 1'b0} + {2'b00, rt};
        case (m)
            2'b00:   pix_f = ct;
            2'b01:   pix_f = 8'd255 - ct;
            2'b10:   pix_f = (ct >= t) ? 8'd255 : 8'd0;
            default: pix_f = sum[9:2];
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        rowbase_d = rowbase_q;
        l_d       = l_q;
        c_d       = c_q;
        mode_d    = mode_q;
        thr_d     = thr_q;
        wa_d      = wa_q;
        wd_d      = wd_q;
        we_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    thr_d   = thr;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (col_q == '0) begin
                    l_d = RD;
                    c_d = RD;
                end else begin
                    we_d = 1'b1;
                    wa_d = DST_BASE + rowbase_q + 32'(col_q) - 32'd1;
                    wd_d = pix_f(mode_q, thr_q, l_q, c_q, RD);
                    l_d  = c_q;
                    c_d  = RD;
                end
                if (col_q == COL_LAST) begin
                    state_d = S_FLUSH;
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            S_FLUSH: begin
                // Right edge: replicate the centre pixel as the right neighbour.
                we_d  = 1'b1;
                wa_d  = DST_BASE + rowbase_q + 32'(COL_LAST);
                wd_d  = pix_f(mode_q, thr_q, l_q, c_q, c_q);
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d     = '0;
                    rowbase_d = '0;
                    state_d   = S_DRAIN;
                end else begin
                    row_d     = row_q + ROW_W'(1);
                    rowbase_d = rowbase_q + 32'(IMG_W);
                    state_d   = S_READ;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ra_d   = SRC_BASE + rowbase_d + 32'(col_d);
        busy_d = (state_d == S_READ) || (state_d == S_FLUSH) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            rowbase_q <= '0;
            l_q       <= '0;
            c_q       <= '0;
            mode_q    <= '0;
            thr_q     <= '0;
            ra_q      <= SRC_BASE;
            wa_q      <= '0;
            wd_q      <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            rowbase_q <= rowbase_d;
            l_q       <= l_d;
            c_q       <= c_d;
            mode_q    <= mode_d;
            thr_q     <= thr_d;
            ra_q      <= ra_d;
            wa_q      <= wa_d;
            wd_q      <= wd_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rA   = ra_q;
    assign wA   = wa_q;
    assign WD   = wd_q;
    assign WE   = we_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_image_filter_engine.sv
// Directed bench for image_filter_engine on a 4x2 image: one out-of-place instance
// (destination at 16) and one in-place instance, each with its own byte memory.
module tb_image_filter_engine;

    localparam int unsigned W = 4;
    localparam int unsigned H = 2;
    localparam int unsigned N = W * H;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    logic        start_a = 1'b0, start_b = 1'b0;
    logic [1:0]  mode_a = 2'b00, mode_b = 2'b00;
    logic [7:0]  thr_a = 8'd0, thr_b = 8'd0;
    logic [31:0] ra_a, wa_a, ra_b, wa_b;
    logic [7:0]  rd_a, wd_a, rd_b, wd_b;
    logic        we_a, busy_a, done_a, we_b, busy_b, done_b;

    image_filter_engine #(.IMG_W(W), .IMG_H(H), .SRC_BASE(32'd0), .DST_BASE(32'd16)) u_dut_a (
        .CLK(CLK), .RST_N(RST_N), .start(start_a), .mode(mode_a), .thr(thr_a),
        .rA(ra_a), .RD(rd_a), .wA(wa_a), .WD(wd_a), .WE(we_a), .busy(busy_a), .done(done_a)
    );

    image_filter_engine #(.IMG_W(W), .IMG_H(H), .SRC_BASE(32'd0), .DST_BASE(32'd0)) u_dut_b (
        .CLK(CLK), .RST_N(RST_N), .start(start_b), .mode(mode_b), .thr(thr_b),
        .rA(ra_b), .RD(rd_b), .wA(wa_b), .WD(wd_b), .WE(we_b), .busy(busy_b), .done(done_b)
    );

    // Byte memories: async read, sync write; the bench preloads through ld_*.
    logic [7:0] mem_a [0:31];
    logic [7:0] mem_b [0:15];
    logic       ld_en_a = 1'b0, ld_en_b = 1'b0;
    logic [4:0] ld_addr = 5'd0;
    logic [7:0] ld_data = 8'd0;

    always @(posedge CLK) begin
        if (ld_en_a)   mem_a[ld_addr] <= ld_data;
        else if (we_a) mem_a[wa_a[4:0]] <= wd_a;
    end

    always @(posedge CLK) begin
        if (ld_en_b)   mem_b[ld_addr[3:0]] <= ld_data;
        else if (we_b) mem_b[wa_b[3:0]] <= wd_b;
    end

    assign rd_a = mem_a[ra_a[4:0]];
    assign rd_b = mem_b[ra_b[3:0]];

    // Activity monitors sampled on the falling edge.
    int          cyc = 0;
    int          busy_cnt_a = 0, we_cnt_a = 0, last_we_cyc_a = 0, done_cyc_a = 0;
    int          busy_cnt_b = 0, we_cnt_b = 0;
    logic [31:0] wlog_a [0:63];

    always @(negedge CLK) begin
        cyc <= cyc + 1;
        if (busy_a) busy_cnt_a <= busy_cnt_a + 1;
        if (we_a) begin
            wlog_a[we_cnt_a % 64] <= wa_a;
            we_cnt_a      <= we_cnt_a + 1;
            last_we_cyc_a <= cyc;
        end
        if (done_a) done_cyc_a <= cyc;
        if (busy_b) busy_cnt_b <= busy_cnt_b + 1;
        if (we_b)   we_cnt_b   <= we_cnt_b + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int img_v [N];
    int exp_v [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_img(input bit to_b);
        for (int i = 0; i < int'(N); i++) begin
            @(negedge CLK);
            ld_en_a = !to_b;
            ld_en_b = to_b;
            ld_addr = 5'(i);
            ld_data = 8'(img_v[i]);
        end
        @(negedge CLK);
        ld_en_a = 1'b0;
        ld_en_b = 1'b0;
    endtask

    task automatic pulse_a(input logic [1:0] m, input logic [7:0] t);
        @(negedge CLK);
        start_a = 1'b1;
        mode_a  = m;
        thr_a   = t;
        @(negedge CLK);
        start_a = 1'b0;
        mode_a  = ~m;
        thr_a   = ~t;
    endtask

    task automatic wait_done_a(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge CLK);
            if (done_a) ok = 1'b1;
        end
        check(tag, 32'(ok), 32'd1);
        @(negedge CLK);
    endtask

    task automatic check_dst_a(input string tag);
        for (int i = 0; i < int'(N); i++)
            check(tag, 32'(mem_a[16 + i]), 32'(exp_v[i]));
    endtask

    int b0, w0;

    initial begin
        // Reset values
        #1;
        check("rst WE", 32'(we_a), 32'd0);
        check("rst wA", wa_a, 32'd0);
        check("rst WD", 32'(wd_a), 32'd0);
        check("rst rA", ra_a, 32'd0);
        check("rst busy", 32'(busy_a), 32'd0);
        check("rst done", 32'(done_a), 32'd0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        // Blur with edge replication, plus cycle-accurate run shape
        img_v = '{10, 20, 30, 40, 0, 255, 255, 0};
        exp_v = '{12, 20, 30, 37, 63, 191, 191, 63};
        load_img(1'b0);
        b0 = busy_cnt_a;
        w0 = we_cnt_a;
        pulse_a(2'b11, 8'd0);
        wait_done_a("blur done");
        check("blur busy cycles", 32'(busy_cnt_a - b0), 32'd11);
        check("blur WE cycles", 32'(we_cnt_a - w0), 32'd8);
        check("done after last WE", 32'(done_cyc_a - last_we_cyc_a), 32'd1);
        for (int i = 0; i < int'(N); i++)
            check("blur wA order", wlog_a[(w0 + i) % 64], 32'(16 + i));
        check_dst_a("blur data");

        // Invert
        img_v = '{0, 200, 255, 1, 10, 20, 30, 40};
        exp_v = '{255, 55, 0, 254, 245, 235, 225, 215};
        load_img(1'b0);
        pulse_a(2'b01, 8'd0);
        wait_done_a("invert done");
        check_dst_a("invert data");

        // Copy
        img_v = '{5, 99, 250, 7, 128, 0, 255, 64};
        exp_v = '{5, 99, 250, 7, 128, 0, 255, 64};
        load_img(1'b0);
        pulse_a(2'b00, 8'd0);
        wait_done_a("copy done");
        check_dst_a("copy data");

        // Threshold at 128 (thr input is flipped right after start)
        img_v = '{127, 128, 0, 255, 129, 1, 200, 128};
        exp_v = '{0, 255, 0, 255, 255, 0, 255, 255};
        load_img(1'b0);
        pulse_a(2'b10, 8'd128);
        wait_done_a("thresh done");
        check_dst_a("thresh data");

        // Reset mid-row 1, then rerun from address 0
        img_v = '{10, 20, 30, 40, 0, 255, 255, 0};
        exp_v = '{12, 20, 30, 37, 63, 191, 191, 63};
        load_img(1'b0);
        pulse_a(2'b11, 8'd0);
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 40 && !hit; i++) begin
                @(negedge CLK);
                if (ra_a == 32'd5) hit = 1'b1;
            end
            check("reach row1", 32'(hit), 32'd1);
        end
        #2 RST_N = 1'b0;
        #1;
        check("abort WE", 32'(we_a), 32'd0);
        check("abort busy", 32'(busy_a), 32'd0);
        check("abort rA", ra_a, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        check("idle after abort", 32'(busy_a), 32'd0);
        w0 = we_cnt_a;
        pulse_a(2'b11, 8'd0);
        check("rerun rA", ra_a, 32'd0);
        check("rerun busy", 32'(busy_a), 32'd1);
        wait_done_a("rerun done");
        check("rerun first wA", wlog_a[w0 % 64], 32'd16);
        check_dst_a("rerun data");

        // In-place blur with a stray start pulse mid-run
        load_img(1'b1);
        b0 = busy_cnt_b;
        w0 = we_cnt_b;
        @(negedge CLK);
        start_b = 1'b1;
        mode_b  = 2'b11;
        @(negedge CLK);
        start_b = 1'b0;
        repeat (3) @(negedge CLK);
        start_b = 1'b1;
        @(negedge CLK);
        start_b = 1'b0;
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 200 && !ok; i++) begin
                @(negedge CLK);
                if (done_b) ok = 1'b1;
            end
            check("inplace done", 32'(ok), 32'd1);
        end
        repeat (3) @(negedge CLK);
        check("inplace busy cycles", 32'(busy_cnt_b - b0), 32'd11);
        check("inplace WE cycles", 32'(we_cnt_b - w0), 32'd8);
        for (int i = 0; i < int'(N); i++)
            check("inplace data", 32'(mem_b[i]), 32'(exp_v[i]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
